// File: rtl/pci_cfg_target.sv
// PCI Type 0 configuration target: claims config cycles with fast DEVSEL#,
// sequences TRDY#/STOP#, generates read parity and turns partial writes into RMW.
module pci_cfg_target #(
    parameter logic [3:0] CMD_CFG_READ  = 4'hA,
    parameter logic [3:0] CMD_CFG_WRITE = 4'hB,
    parameter logic [2:0] FUNC_NUM      = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_n,
    input  logic        irdy_n,
    input  logic        idsel,
    input  logic [3:0]  cbe_n_in,
    input  logic [31:0] ad_in,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic        trdy_n,
    output logic        devsel_n,
    output logic        stop_n,
    output logic        ctrl_oe,
    output logic        par_out,
    output logic        par_oe,
    output logic        cfg_enable,
    output logic        cfg_iswrite,
    output logic [5:0]  cfg_offset,
    output logic [31:0] cfg_write_val,
    input  logic [31:0] cfg_read_val,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RD_REQ    = 4'd1,
        RD_WAIT   = 4'd2,
        RD_XFER   = 4'd3,
        WR_WAIT   = 4'd4,
        WR_READ   = 4'd5,
        WR_MERGE  = 4'd6,
        WR_COMMIT = 4'd7,
        WR_ACK    = 4'd8,
        TURN      = 4'd9
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        bus_idle_r;
    logic [31:0] wr_data_r;
    logic [3:0]  wr_be_r;
    logic        accept_s;
    logic        claim_nxt_s;
    logic        xfer_nxt_s;
    logic        strobe_nxt_s;
    logic        enter_xfer_s;

    function automatic logic read_parity(input logic [31:0] data, input logic [3:0] be_n);
        return ^{data, be_n};
    endfunction

    // Disabled byte lanes (C/BE# high) keep the current register contents.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] upd,
                                                input logic [3:0] be_n);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be_n[i] ? cur[8*i +: 8] : upd[8*i +: 8];
        end
        return m;
    endfunction

    assign accept_s = (state_r == IDLE) && bus_idle_r && !frame_n && idsel &&
                      (ad_in[1:0] == 2'b00) && (ad_in[10:8] == FUNC_NUM) &&
                      ((cbe_n_in == CMD_CFG_READ) || (cbe_n_in == CMD_CFG_WRITE));

    assign claim_nxt_s  = (state_nxt_s != IDLE) && (state_nxt_s != TURN);
    assign xfer_nxt_s   = (state_nxt_s == RD_XFER) || (state_nxt_s == WR_ACK);
    assign strobe_nxt_s = (state_nxt_s == RD_REQ) || (state_nxt_s == WR_READ) ||
                          (state_nxt_s == WR_COMMIT);
    assign enter_xfer_s = xfer_nxt_s && (state_nxt_s != state_r);

    // Next-state decode for the transaction sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (cbe_n_in == CMD_CFG_READ) ? RD_REQ : WR_WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_REQ:  state_nxt_s = RD_WAIT;
            RD_WAIT: state_nxt_s = RD_XFER;
            RD_XFER: begin
                if (!irdy_n) begin
                    state_nxt_s = TURN;
                end else begin
                    state_nxt_s = RD_XFER;
                end
            end
            WR_WAIT: begin
                if (irdy_n) begin
                    state_nxt_s = WR_WAIT;
                end else if (cbe_n_in == 4'b1111) begin
                    state_nxt_s = WR_ACK;
                end else if (cbe_n_in == 4'b0000) begin
                    state_nxt_s = WR_COMMIT;
                end else begin
                    state_nxt_s = WR_READ;
                end
            end
            WR_READ:   state_nxt_s = WR_MERGE;
            WR_MERGE:  state_nxt_s = WR_COMMIT;
            WR_COMMIT: state_nxt_s = WR_ACK;
            WR_ACK: begin
                if (!irdy_n) begin
                    state_nxt_s = TURN;
                end else begin
                    state_nxt_s = WR_ACK;
                end
            end
            TURN:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and bus/port controls, registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            bus_idle_r  <= 1'b0;
            devsel_n    <= 1'b1;
            trdy_n      <= 1'b1;
            stop_n      <= 1'b1;
            ctrl_oe     <= 1'b0;
            ad_oe       <= 1'b0;
            par_oe      <= 1'b0;
            cfg_enable  <= 1'b0;
            cfg_iswrite <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bus_idle_r  <= frame_n & irdy_n;
            devsel_n    <= ~claim_nxt_s;
            trdy_n      <= ~xfer_nxt_s;
            ctrl_oe     <= claim_nxt_s | (state_nxt_s == TURN);
            ad_oe       <= (state_nxt_s == RD_XFER);
            par_oe      <= (state_nxt_s == TURN) && (state_r == RD_XFER);
            cfg_enable  <= strobe_nxt_s;
            cfg_iswrite <= (state_nxt_s == WR_COMMIT);
            busy        <= (state_nxt_s != IDLE);
            // STOP# reflects FRAME# only at entry to the data-transfer state, then holds.
            if (enter_xfer_s) begin
                stop_n <= frame_n;
            end else if (!xfer_nxt_s) begin
                stop_n <= 1'b1;
            end else begin
                stop_n <= stop_n;
            end
        end
    end

    // Address/data path: offset latch, read data, parity, write capture and merge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_offset    <= 6'd0;
            ad_out        <= 32'h0000_0000;
            par_out       <= 1'b0;
            wr_data_r     <= 32'h0000_0000;
            wr_be_r       <= 4'b0000;
            cfg_write_val <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                cfg_offset <= ad_in[7:2];
            end
            if (state_r == RD_WAIT) begin
                ad_out <= cfg_read_val;
            end
            if ((state_r == RD_XFER) && !irdy_n) begin
                par_out <= read_parity(ad_out, cbe_n_in);
            end
            if ((state_r == WR_WAIT) && !irdy_n) begin
                wr_data_r <= ad_in;
                wr_be_r   <= cbe_n_in;
                if (cbe_n_in == 4'b0000) begin
                    cfg_write_val <= ad_in;
                end
            end
            if (state_r == WR_MERGE) begin
                cfg_write_val <= merge_bytes(cfg_read_val, wr_data_r, wr_be_r);
            end
        end
    end

endmodule

// File: tb/tb_pci_cfg_target.sv
// Randomized bench for pci_cfg_target: a PCI master driver, a config-register
// store behind the port, and a transaction-level reference of expected behaviour.
module tb_pci_cfg_target;

    localparam logic [3:0] CMD_RD = 4'hA;
    localparam logic [3:0] CMD_WR = 4'hB;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_n, irdy_n, idsel;
    logic [3:0]  cbe_n_in;
    logic [31:0] ad_in;
    logic [31:0] ad_out;
    logic        ad_oe, trdy_n, devsel_n, stop_n, ctrl_oe, par_out, par_oe;
    logic        cfg_enable, cfg_iswrite, busy;
    logic [5:0]  cfg_offset;
    logic [31:0] cfg_write_val, cfg_read_val;

    logic [31:0] mem      [64];
    logic [31:0] ref_regs [64];
    int          rd_cnt, wr_cnt;
    int          n_checks = 0;
    int          n_err = 0;

    pci_cfg_target dut (
        .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .idsel(idsel),
        .cbe_n_in(cbe_n_in), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .trdy_n(trdy_n), .devsel_n(devsel_n), .stop_n(stop_n), .ctrl_oe(ctrl_oe),
        .par_out(par_out), .par_oe(par_oe), .cfg_enable(cfg_enable),
        .cfg_iswrite(cfg_iswrite), .cfg_offset(cfg_offset), .cfg_write_val(cfg_write_val),
        .cfg_read_val(cfg_read_val), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h11E8_1234;
        else if (i == 15) return 32'h0000_0100;
        else return 32'hA5C3_0F96 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Config register store: read data valid the cycle after a read strobe, junk otherwise.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            rd_cnt       <= 0;
            wr_cnt       <= 0;
            cfg_read_val <= 32'h0000_0000;
        end else begin
            cfg_read_val <= 32'hDEAD_BEEF;
            if (cfg_enable && !cfg_iswrite) begin
                cfg_read_val <= mem[cfg_offset];
                rd_cnt       <= rd_cnt + 1;
            end
            if (cfg_enable && cfg_iswrite) begin
                mem[cfg_offset] <= cfg_write_val;
                wr_cnt          <= wr_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_ref();
        for (int i = 0; i < 64; i++) ref_regs[i] = init_word(i);
    endtask

    task automatic bus_idle();
        frame_n  = 1'b1;
        irdy_n   = 1'b1;
        idsel    = 1'b0;
        cbe_n_in = 4'hF;
        ad_in    = $urandom;
    endtask

    task automatic addr_phase(input logic [5:0] off, input logic [3:0] cmd);
        logic [31:0] r;
        r        = $urandom;
        frame_n  = 1'b0;
        irdy_n   = 1'b1;
        idsel    = 1'b1;
        cbe_n_in = cmd;
        ad_in    = {r[31:11], 3'b000, off, 2'b00};
    endtask

    task automatic read_txn(input logic [5:0] off, input logic [3:0] be, input int dly, input bit hold);
        logic [31:0] exp;
        logic        fr2;
        bit          fin;
        int          rd0, wr0;
        exp = ref_regs[off];
        fr2 = 1'b1;
        fin = 1'b0;
        bus_idle();
        tick();
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        addr_phase(off, CMD_RD);
        tick();
        check("rd_devsel_c1", devsel_n, 1'b0);
        check("rd_strobe_c1", {cfg_enable, cfg_iswrite, ctrl_oe, ad_oe}, 4'b1010);
        check("rd_offset", cfg_offset, off);
        for (int c = 1; c < 20; c++) begin
            idsel    = 1'b0;
            cbe_n_in = be;
            ad_in    = $urandom;
            irdy_n   = (c > dly) ? 1'b0 : 1'b1;
            frame_n  = (!irdy_n && !hold) ? 1'b1 : 1'b0;
            if (c == 2) fr2 = frame_n;
            fin = (c >= 3) && !irdy_n;
            tick();
            if (fin) break;
            if (c == 1) begin
                check("rd_wait", {devsel_n, cfg_enable, trdy_n, ad_oe}, 4'b0010);
            end else begin
                check("rd_xfer_ctl", {devsel_n, trdy_n, ad_oe, stop_n}, {3'b001, fr2});
                check("rd_data", ad_out, exp);
            end
        end
        check("rd_done", fin, 1'b1);
        bus_idle();
        check("rd_turn", {trdy_n, devsel_n, stop_n, ctrl_oe, ad_oe, par_oe}, 6'b111101);
        check("rd_parity", par_out, ^{exp, be});
        tick();
        check("rd_idle", {ctrl_oe, par_oe, busy, devsel_n}, 4'b0001);
        check("rd_nreads", rd_cnt - rd0, 1);
        check("rd_nwrites", wr_cnt - wr0, 0);
    endtask

    task automatic write_txn(input logic [5:0] off, input logic [31:0] data, input logic [3:0] be,
                             input int dly, input bit hold);
        logic [31:0] mask, merged;
        int          nacc, rd0, wr0;
        bit          cap;
        logic        fr;
        mask   = {{8{~be[3]}}, {8{~be[2]}}, {8{~be[1]}}, {8{~be[0]}}};
        merged = (data & mask) | (ref_regs[off] & ~mask);
        nacc   = (be == 4'hF) ? 0 : ((be == 4'h0) ? 1 : 2);
        bus_idle();
        tick();
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        addr_phase(off, CMD_WR);
        tick();
        check("wr_claim_c1", {devsel_n, ctrl_oe, cfg_enable, busy}, 4'b0101);
        cap = 1'b0;
        for (int c = 1; c < 20 && !cap; c++) begin
            idsel    = 1'b0;
            cbe_n_in = be;
            ad_in    = data;
            irdy_n   = (c > dly) ? 1'b0 : 1'b1;
            frame_n  = (!irdy_n && !hold) ? 1'b1 : 1'b0;
            cap      = !irdy_n;
            tick();
            if (!cap) check("wr_wait", {devsel_n, cfg_enable, trdy_n}, 3'b001);
        end
        check("wr_captured", cap, 1'b1);
        fr = frame_n;
        if (nacc == 2) begin
            check("wr_rmw_read", {cfg_enable, cfg_iswrite, cfg_offset}, {2'b10, off});
            tick();
            check("wr_merge", {cfg_enable, trdy_n}, 2'b01);
            tick();
        end
        if (nacc >= 1) begin
            check("wr_commit", {cfg_enable, cfg_iswrite, cfg_offset}, {2'b11, off});
            check("wr_value", cfg_write_val, merged);
            tick();
        end
        check("wr_ack", {devsel_n, trdy_n, stop_n, cfg_enable}, {2'b00, fr, 1'b0});
        tick();
        bus_idle();
        check("wr_turn", {trdy_n, devsel_n, stop_n, ctrl_oe, ad_oe, par_oe}, 6'b111100);
        tick();
        check("wr_idle", {ctrl_oe, par_oe, busy, devsel_n}, 4'b0001);
        check("wr_nreads", rd_cnt - rd0, (nacc == 2) ? 1 : 0);
        check("wr_nwrites", wr_cnt - wr0, (nacc > 0) ? 1 : 0);
        if (nacc > 0) ref_regs[off] = merged;
    endtask

    task automatic abort_txn(input int kind, input bit no_idle);
        int rd0, wr0;
        bus_idle();
        tick();
        if (no_idle) begin
            addr_phase(6'd1, CMD_RD);
            idsel = 1'b0;
            tick();
        end
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        addr_phase(6'($urandom_range(0, 63)), ($urandom_range(0, 1) == 0) ? CMD_RD : CMD_WR);
        if (!no_idle) begin
            case (kind)
                0:       idsel = 1'b0;
                1:       cbe_n_in = 4'b0010;
                2:       ad_in[1:0] = 2'b01;
                default: ad_in[10:8] = 3'b001;
            endcase
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            check("abort_quiet", {devsel_n, ctrl_oe, cfg_enable, busy}, 4'b1000);
            idsel    = 1'b0;
            frame_n  = 1'b1;
            irdy_n   = 1'b0;
            cbe_n_in = 4'h0;
        end
        bus_idle();
        check("abort_nacc", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
    endtask

    task automatic reset_mid_read();
        bus_idle();
        tick();
        addr_phase(6'd2, CMD_RD);
        tick();
        idsel   = 1'b0;
        irdy_n  = 1'b0;
        frame_n = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("rst_release", {ad_oe, ctrl_oe, par_oe, cfg_enable, busy, devsel_n, trdy_n, stop_n},
              8'b00000111);
        bus_idle();
        tick();
        rst = 1'b1;
        tick();
        check("rst_idle", {busy, devsel_n, ctrl_oe}, 3'b010);
        init_ref();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus_idle();
        init_ref();
        repeat (3) tick();
        check("reset_ctl",
              {trdy_n, devsel_n, stop_n, ad_oe, ctrl_oe, par_oe, par_out, cfg_enable, cfg_iswrite, busy},
              10'b1110000000);
        check("reset_ad_out", ad_out, 32'h0);
        check("reset_cfg", {cfg_offset, cfg_write_val}, 38'h0);
        rst = 1'b1;
        tick();

        read_txn(6'd0, 4'b0000, 0, 1'b0);
        write_txn(6'h0F, 32'hAABB_CC5A, 4'b1110, 0, 1'b0);
        read_txn(6'h0F, 4'b0000, 0, 1'b0);
        write_txn(6'h0F, 32'h0000_000B, 4'b0000, 0, 1'b0);
        write_txn(6'd5, 32'h1234_5678, 4'b1111, 0, 1'b0);
        read_txn(6'd5, 4'b0101, 2, 1'b0);
        for (int k = 0; k < 4; k++) abort_txn(k, 1'b0);
        abort_txn(0, 1'b1);
        read_txn(6'd3, 4'b0000, 0, 1'b1);
        reset_mid_read();
        read_txn(6'd0, 4'b0011, 1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int          sel, bsel;
            logic [3:0]  be;
            logic [5:0]  off;
            sel  = $urandom_range(0, 8);
            bsel = $urandom_range(0, 5);
            off  = 6'($urandom_range(0, 63));
            be   = (bsel == 0) ? 4'h0 : ((bsel == 1) ? 4'hF : 4'($urandom_range(0, 15)));
            if (sel < 4) begin
                read_txn(off, be, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
            end else if (sel < 8) begin
                write_txn(off, $urandom, be, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
            end else begin
                abort_txn($urandom_range(0, 3), $urandom_range(0, 1) == 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
